gsense_link_supervisor: RTL and testbench

Sequences link bring-up and recovery for the GSENSE LVDS receiver top.
- Drives the receiver's `enable` input; a rising edge there starts training.
- Bounds training with a timeout and retries a limited number of times.
- Once the link is up, watches per-lane lock and retrains automatically when lock is lost.
- Runs in the parallel clock domain (clkdiv2) and gives the host a single clean link-status view.

---
 rtl/gsense_pkg.sv | 30 +++
 rtl/gsense_loss_filter.sv | 37 +++
 rtl/gsense_link_supervisor.sv | 165 ++++++++++++++++
 tb/tb_gsense_link_supervisor.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsense_pkg.sv
// Shared state encoding and parameter defaults for the GSENSE link supervisor.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package gsense_pkg;

    // Debug encoding is visible on sup_state, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GAP     = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_FAILCHK = 3'd4,
        ST_UP      = 3'd5,
        ST_FAIL    = 3'd6
    } sup_state_t;

    localparam int GAP_CYCLES_DEF     = 16;
    localparam int TIMEOUT_CYCLES_DEF = 65536;
    localparam int MAX_RETRIES_DEF    = 3;
    localparam int LOSS_FILTER_DEF    = 8;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gsense_loss_filter.sv
// Consecutive-cycle lock-loss filter: trips after LOSS_FILTER back-to-back bad cycles.
// Latency: trip is registered; it rises the cycle after the LOSS_FILTER-th bad sample.
// Backpressure: none; a single good cycle or clr restarts the count.
//
// Ports: clk, reset_n (sync, active low), clr (hold count at zero), bad (lock lost
// this cycle), trip (run of bad cycles reached LOSS_FILTER; held until cleared).
module gsense_loss_filter
    import gsense_pkg::*;
#(
    parameter int LOSS_FILTER = LOSS_FILTER_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic bad,
    output logic trip
);

    localparam int             CW    = $clog2(LOSS_FILTER + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(LOSS_FILTER);

    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_cnt <= '0;
        end else if (clr || !bad) begin
            run_cnt <= '0;
        end else if (run_cnt != LIMIT) begin
            // Saturate so trip stays up until the owner clears it.
            run_cnt <= run_cnt + CW'(1);
        end
    end

    assign trip = (run_cnt == LIMIT);

endmodule

// File: rtl/gsense_link_supervisor.sv
// Link bring-up/recovery sequencer for the GSENSE LVDS receiver (clkdiv2 domain).
// Latency: all outputs registered; train_req acts on the next edge.
// Backpressure: none; train_req always wins and restarts the bring-up at GAP.
//
// Ports: clk, reset_n (sync, active low), train_req, auto_retrain, training_done,
// lane_locked[LANES] in; enable, link_up, link_fail, retry_cnt[2], sup_state[3] out.
// Optional GSENSE_LINK_STATS_EN adds relock_cnt[16] and timeout_cnt[16] outputs.
module gsense_link_supervisor
    import gsense_pkg::*;
#(
    parameter int LANES          = 32,
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int MAX_RETRIES    = MAX_RETRIES_DEF,
    parameter int LOSS_FILTER    = LOSS_FILTER_DEF,
    parameter int CNT_W          = 17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             train_req,
    input  logic             auto_retrain,
    input  logic             training_done,
    input  logic [LANES-1:0] lane_locked,
    output logic             enable,
    output logic             link_up,
    output logic             link_fail,
    output logic [1:0]       retry_cnt,
    output logic [2:0]       sup_state
`ifdef GSENSE_LINK_STATS_EN
    ,
    output logic [15:0]      relock_cnt,
    output logic [15:0]      timeout_cnt
`endif
);

    localparam int               GAP_W       = $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    // retry_cnt saturates at 3, so a larger limit behaves like 3.
    localparam logic [1:0]       RETRY_LIMIT = (MAX_RETRIES >= 3) ? 2'd3 : 2'(MAX_RETRIES);

    sup_state_t       state;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             done_seen_low;
    logic [1:0]       retry_nxt;
    logic             loss_bad;
    logic             loss_clr;
    logic             loss_trip;

    assign sup_state = state;
    assign retry_nxt = sat_inc2(retry_cnt);
    assign loss_bad  = ~&lane_locked;
    assign loss_clr  = (state != ST_UP);

    gsense_loss_filter #(
        .LOSS_FILTER (LOSS_FILTER)
    ) u_loss_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (loss_clr),
        .bad     (loss_bad),
        .trip    (loss_trip)
    );

    // Outputs are updated together with the state they belong to, so
    // enable/link_up/link_fail line up exactly with sup_state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            enable        <= 1'b0;
            link_up       <= 1'b0;
            link_fail     <= 1'b0;
            retry_cnt     <= 2'd0;
            gap_cnt       <= '0;
            tmo_cnt       <= '0;
            done_seen_low <= 1'b0;
`ifdef GSENSE_LINK_STATS_EN
            relock_cnt    <= 16'd0;
            timeout_cnt   <= 16'd0;
`endif
        end else if (train_req) begin
            // Host request restarts from any state, including a loss trip
            // in the same cycle (not counted as a relock).
            state     <= ST_GAP;
            gap_cnt   <= '0;
            retry_cnt <= 2'd0;
            enable    <= 1'b0;
            link_up   <= 1'b0;
            link_fail <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= ST_START;
                        enable <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_START: begin
                    state         <= ST_WAIT;
                    tmo_cnt       <= '0;
                    done_seen_low <= 1'b0;
                end
                ST_WAIT: begin
                    // A done level left over from an earlier run is only
                    // accepted after it has been seen low once.
                    if (!training_done) begin
                        done_seen_low <= 1'b1;
                    end
                    if (training_done && done_seen_low) begin
                        state   <= ST_UP;
                        link_up <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= ST_FAILCHK;
`ifdef GSENSE_LINK_STATS_EN
                        timeout_cnt <= sat_inc16(timeout_cnt);
`endif
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ST_FAILCHK: begin
                    retry_cnt <= retry_nxt;
                    enable    <= 1'b0;
                    if (retry_nxt < RETRY_LIMIT) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                    end else begin
                        state     <= ST_FAIL;
                        link_fail <= 1'b1;
                    end
                end
                ST_UP: begin
                    if (loss_trip) begin
                        enable  <= 1'b0;
                        link_up <= 1'b0;
                        if (auto_retrain) begin
                            state     <= ST_GAP;
                            gap_cnt   <= '0;
                            retry_cnt <= 2'd0;
`ifdef GSENSE_LINK_STATS_EN
                            relock_cnt <= sat_inc16(relock_cnt);
`endif
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_FAIL: begin
                end
                default: begin
                    state     <= ST_IDLE;
                    enable    <= 1'b0;
                    link_up   <= 1'b0;
                    link_fail <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gsense_link_supervisor.sv
`timescale 1ns/1ps
module tb_gsense_link_supervisor;

    localparam int LANES = 32;
    localparam int GAP   = 16;
    localparam int TMO   = 600;
    localparam int MAXR  = 3;
    localparam int LF    = 8;
    localparam int CW    = 10;

    localparam logic [LANES-1:0] ALL_OK   = '1;
    localparam logic [LANES-1:0] ONE_DOWN = ALL_OK ^ (LANES'(1) << 5);

    localparam int P_IDLE = 0, P_GAP = 1, P_START = 2, P_WAIT = 3;
    localparam int P_FAILCHK = 4, P_UP = 5, P_FAIL = 6;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             train_req;
    logic             auto_retrain;
    logic             training_done;
    logic [LANES-1:0] lane_locked;
    wire              enable;
    wire              link_up;
    wire              link_fail;
    wire  [1:0]       retry_cnt;
    wire  [2:0]       sup_state;
`ifdef GSENSE_LINK_STATS_EN
    wire  [15:0]      relock_cnt;
    wire  [15:0]      timeout_cnt;
`endif

    gsense_link_supervisor #(
        .LANES          (LANES),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES    (MAXR),
        .LOSS_FILTER    (LF),
        .CNT_W          (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .train_req     (train_req),
        .auto_retrain  (auto_retrain),
        .training_done (training_done),
        .lane_locked   (lane_locked),
        .enable        (enable),
        .link_up       (link_up),
        .link_fail     (link_fail),
        .retry_cnt     (retry_cnt),
        .sup_state     (sup_state)
`ifdef GSENSE_LINK_STATS_EN
        ,
        .relock_cnt    (relock_cnt),
        .timeout_cnt   (timeout_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] dut_outs();
        return {sup_state, enable, link_up, link_fail, retry_cnt};
    endfunction

    function automatic logic [7:0] pack(input int st, input bit en, input bit up,
                                        input bit fl, input int rt);
        return {3'(st), en, up, fl, 2'(rt)};
    endfunction

    // ---------------- behavioural reference model ----------------
    // Tracks which phase the link is in and how long it has been there;
    // every phase change restarts the age and the lock-loss run.
    int m_ph = P_IDLE, m_age = 0, m_bad = 0, m_retry = 0;
    int m_relock = 0, m_tmo = 0;
    bit m_seen_low = 0;

    always @(posedge clk) begin
        int old_ph;
        old_ph = m_ph;
        if (!reset_n) begin
            m_ph = P_IDLE; m_age = 0; m_bad = 0; m_retry = 0;
            m_relock = 0; m_tmo = 0; m_seen_low = 0;
        end else if (train_req) begin
            m_ph = P_GAP; m_age = 0; m_bad = 0; m_retry = 0;
        end else begin
            case (m_ph)
                P_GAP:   if (m_age == GAP - 1) m_ph = P_START; else m_age++;
                P_START: begin m_ph = P_WAIT; m_seen_low = 0; end
                P_WAIT: begin
                    if (training_done && m_seen_low) m_ph = P_UP;
                    else if (m_age == TMO - 1) begin
                        m_ph = P_FAILCHK;
                        if (m_tmo < 65535) m_tmo++;
                    end else m_age++;
                    if (!training_done) m_seen_low = 1;
                end
                P_FAILCHK: begin
                    if (m_retry < 3) m_retry++;
                    m_ph = (m_retry < MAXR) ? P_GAP : P_FAIL;
                end
                P_UP: begin
                    if (m_bad >= LF) begin
                        if (auto_retrain) begin
                            m_ph = P_GAP; m_retry = 0;
                            if (m_relock < 65535) m_relock++;
                        end else m_ph = P_IDLE;
                    end else m_bad = (lane_locked == ALL_OK) ? 0 : m_bad + 1;
                end
                default: ;
            endcase
            if (m_ph != old_ph) begin m_age = 0; m_bad = 0; end
        end
    end

    function automatic logic [7:0] m_outs();
        bit en;
        en = (m_ph == P_START) || (m_ph == P_WAIT) || (m_ph == P_FAILCHK) || (m_ph == P_UP);
        return pack(m_ph, en, m_ph == P_UP, m_ph == P_FAIL, m_retry);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit         rst_n;
        bit         req;
        bit         done;
        bit         lok;
        bit         aut;
        int         n;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    function automatic vec_t mk(input bit r, input bit q, input bit d, input bit l, input bit a,
                                input int n, input logic [7:0] e);
        vec_t v;
        v.rst_n = r; v.req = q; v.done = d; v.lok = l; v.aut = a; v.n = n; v.exp = e;
        return v;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; train_req = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, e_rise, k, early_up, rises, low_run, bad_low, bad_left, mode;
        bit prev_en;
        logic [LANES-1:0] mask;

        reset_n = 1'b0; train_req = 1'b0; auto_retrain = 1'b1;
        training_done = 1'b0; lane_locked = ALL_OK;
        @(negedge clk);

        //            rst req done lok aut  n       st       en up fl rt
        vecs[0]  = mk(0, 0, 0, 1, 1, 2,       pack(P_IDLE,    0, 0, 0, 0));
        vecs[1]  = mk(1, 0, 0, 1, 1, 5,       pack(P_IDLE,    0, 0, 0, 0));
        vecs[2]  = mk(1, 1, 0, 1, 1, 1,       pack(P_GAP,     0, 0, 0, 0));
        vecs[3]  = mk(1, 0, 0, 1, 1, 15,      pack(P_GAP,     0, 0, 0, 0));
        vecs[4]  = mk(1, 0, 0, 1, 1, 1,       pack(P_START,   1, 0, 0, 0));
        vecs[5]  = mk(1, 0, 1, 1, 1, 1,       pack(P_WAIT,    1, 0, 0, 0));
        vecs[6]  = mk(1, 0, 1, 1, 1, 10,      pack(P_WAIT,    1, 0, 0, 0));
        vecs[7]  = mk(1, 0, 0, 1, 1, 1,       pack(P_WAIT,    1, 0, 0, 0));
        vecs[8]  = mk(1, 0, 1, 1, 1, 1,       pack(P_UP,      1, 1, 0, 0));
        vecs[9]  = mk(1, 0, 1, 0, 1, 7,       pack(P_UP,      1, 1, 0, 0));
        vecs[10] = mk(1, 0, 1, 1, 1, 1,       pack(P_UP,      1, 1, 0, 0));
        vecs[11] = mk(1, 0, 1, 0, 1, 8,       pack(P_UP,      1, 1, 0, 0));
        vecs[12] = mk(1, 0, 1, 0, 1, 1,       pack(P_GAP,     0, 0, 0, 0));
        vecs[13] = mk(1, 0, 0, 1, 1, 16,      pack(P_START,   1, 0, 0, 0));
        vecs[14] = mk(1, 0, 0, 1, 1, 1,       pack(P_WAIT,    1, 0, 0, 0));
        vecs[15] = mk(1, 0, 0, 1, 1, TMO - 1, pack(P_WAIT,    1, 0, 0, 0));
        vecs[16] = mk(1, 0, 0, 1, 1, 1,       pack(P_FAILCHK, 1, 0, 0, 0));
        vecs[17] = mk(1, 0, 0, 1, 1, 1,       pack(P_GAP,     0, 0, 0, 1));
        vecs[18] = mk(1, 1, 0, 1, 1, 1,       pack(P_GAP,     0, 0, 0, 0));
        vecs[19] = mk(1, 0, 0, 1, 0, 16,      pack(P_START,   1, 0, 0, 0));
        vecs[20] = mk(1, 0, 0, 1, 0, 1,       pack(P_WAIT,    1, 0, 0, 0));
        vecs[21] = mk(1, 0, 0, 1, 0, 1,       pack(P_WAIT,    1, 0, 0, 0));
        vecs[22] = mk(1, 0, 1, 1, 0, 1,       pack(P_UP,      1, 1, 0, 0));
        vecs[23] = mk(1, 0, 1, 0, 0, 8,       pack(P_UP,      1, 1, 0, 0));
        vecs[24] = mk(1, 0, 1, 0, 0, 1,       pack(P_IDLE,    0, 0, 0, 0));
        vecs[25] = mk(1, 0, 1, 1, 0, 20,      pack(P_IDLE,    0, 0, 0, 0));
        vecs[26] = mk(1, 1, 1, 1, 0, 1,       pack(P_GAP,     0, 0, 0, 0));
        vecs[27] = mk(0, 0, 1, 1, 0, 1,       pack(P_IDLE,    0, 0, 0, 0));

        for (int i = 0; i < NV; i++) begin
            reset_n       = vecs[i].rst_n;
            train_req     = vecs[i].req;
            training_done = vecs[i].done;
            lane_locked   = vecs[i].lok ? ALL_OK : ONE_DOWN;
            auto_retrain  = vecs[i].aut;
            repeat (vecs[i].n) tick();
            chk($sformatf("vec%0d", i), dut_outs(), vecs[i].exp);
        end
        train_req = 1'b0; lane_locked = ALL_OK; auto_retrain = 1'b1; training_done = 1'b0;

        // Normal bring-up with exact timing: request in cycle 10, done 500 after enable.
        do_reset();
        cyc = 0;
        repeat (10) begin tick(); cyc++; end
        train_req = 1'b1; tick(); cyc++; train_req = 1'b0;
        while (!enable && cyc < 200) begin tick(); cyc++; end
        chk("t1_enable_rise_cycle", cyc, 27);
        e_rise = cyc;
        while (cyc < e_rise + 500) begin tick(); cyc++; end
        chk("t1_wait_before_done", dut_outs(), pack(P_WAIT, 1, 0, 0, 0));
        training_done = 1'b1; tick(); cyc++;
        chk("t1_up_after_done", dut_outs(), pack(P_UP, 1, 1, 0, 0));

        // Stale done held high across the request must not be accepted.
        do_reset();
        training_done = 1'b1;
        tick(); tick();
        train_req = 1'b1; tick(); train_req = 1'b0;
        k = 0;
        while (!enable && k < 100) begin tick(); k++; end
        chk("t2_enable_rise", enable, 1);
        early_up = 0;
        for (int j = 0; j < 103; j++) begin
            if (j == 3) training_done = 1'b0;
            tick();
            if (link_up) early_up++;
        end
        chk("t2_no_premature_up", early_up, 0);
        training_done = 1'b1; tick();
        chk("t2_up_after_low_high", dut_outs(), pack(P_UP, 1, 1, 0, 0));
        training_done = 1'b0;

        // Timeouts until retries are exhausted.
        do_reset();
        train_req = 1'b1; tick(); train_req = 1'b0;
        prev_en = 1'b0; rises = 0; low_run = 0; bad_low = 0;
        for (int j = 0; j < 4000 && !link_fail; j++) begin
            if (enable && !prev_en) begin
                rises++;
                if (rises > 1 && low_run != GAP) bad_low++;
            end
            low_run = enable ? 0 : low_run + 1;
            prev_en = enable;
            tick();
        end
        chk("t3_enable_pulses", rises, 3);
        chk("t3_gap_low_len", bad_low, 0);
        chk("t3_fail_state", dut_outs(), pack(P_FAIL, 0, 0, 1, 3));
`ifdef GSENSE_LINK_STATS_EN
        chk("t3_timeout_cnt", timeout_cnt, 3);
`endif
        repeat (5) tick();
        chk("t3_fail_holds", dut_outs(), pack(P_FAIL, 0, 0, 1, 3));
        train_req = 1'b1; tick(); train_req = 1'b0;
        chk("t3_fail_exit", dut_outs(), pack(P_GAP, 0, 0, 0, 0));

        // Reset pulse at WAIT cycle 20.
        do_reset();
        train_req = 1'b1; tick(); train_req = 1'b0;
        k = 0;
        while (sup_state != 3'(P_WAIT) && k < 100) begin tick(); k++; end
        repeat (20) tick();
        chk("t6_in_wait", dut_outs(), pack(P_WAIT, 1, 0, 0, 0));
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        chk("t6_after_reset", dut_outs(), pack(P_IDLE, 0, 0, 0, 0));

        // Randomized traffic against the reference model.
        do_reset();
        bad_left = 0; mode = 0; mask = ALL_OK;
        for (int i = 0; i < 20000; i++) begin
            if (i % 2500 == 0) mode = $urandom_range(0, 1);
            reset_n   = ($urandom_range(0, 1499) != 0);
            train_req = (i % 2500 == 1) ||
                        (mode == 1 ? ($urandom_range(0, 1499) == 0) : ($urandom_range(0, 249) == 0));
            if ($urandom_range(0, 399) == 0) auto_retrain = ~auto_retrain;
            if (mode == 1) training_done = 1'b0;
            else if ($urandom_range(0, 29) == 0) training_done = ~training_done;
            if (bad_left > 0) bad_left--;
            else if ($urandom_range(0, 49) == 0) begin
                bad_left = $urandom_range(1, 12);
                mask = ALL_OK ^ (LANES'(1) << $urandom_range(0, LANES - 1));
            end
            lane_locked = (bad_left > 0) ? mask : ALL_OK;
            tick();
            chk($sformatf("rand_c%0d", i), dut_outs(), m_outs());
`ifdef GSENSE_LINK_STATS_EN
            chk($sformatf("rand_stats_c%0d", i), {relock_cnt, timeout_cnt},
                {16'(m_relock), 16'(m_tmo)});
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
